// File: rtl/sck_alu_pkg.sv
// Shared types and constants for the sck_alu datapath ALU.
// Operation encodings and flag bit positions used by the RTL and the bench.
package sck_alu_pkg;

  localparam int WIDTH = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/sck_alu_comb.sv
// Combinational core of sck_alu: operand-B select, operation decode,
// result and Z/N/C/V flag generation.
module sck_alu_comb #(
  parameter int WIDTH = sck_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] arg0,
  input  logic [WIDTH-1:0] arg1,
  input  logic [1:0]       oper,
  input  logic             imm,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);
  import sck_alu_pkg::*;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic             ovf;

  assign op_b = imm ? data : arg1;

  // Extra top bit is the carry-out for ADD and the borrow for SUB.
  assign sum  = {1'b0, arg0} + {1'b0, op_b};
  assign diff = {1'b0, arg0} - {1'b0, op_b};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (alu_op_t'(oper))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (arg0[WIDTH-1] == op_b[WIDTH-1]) &&
                 (sum[WIDTH-1] != arg0[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (arg0[WIDTH-1] != op_b[WIDTH-1]) &&
                 (diff[WIDTH-1] != arg0[WIDTH-1]);
      end
      OP_AND: result = arg0 & op_b;
      OP_OR:  result = arg0 | op_b;
      default: result = '0;
    endcase
  end

  always_comb begin
    flag         = 4'b0000;
    flag[FLAG_Z] = (result == '0);
    flag[FLAG_N] = result[WIDTH-1];
    flag[FLAG_C] = carry;
    flag[FLAG_V] = ovf;
  end

endmodule

// File: rtl/sck_alu.sv
// Registered signed ALU: the combinational core feeds a result/flag register
// with synchronous active-high reset and one cycle of latency.
module sck_alu #(
  parameter int WIDTH = sck_alu_pkg::WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [1:0]       i_oper,
  input  logic             i_imm,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag
);

  logic [WIDTH-1:0] result_d;
  logic [3:0]       flag_d;

  sck_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .arg0   (i_arg0),
    .arg1   (i_arg1),
    .oper   (i_oper),
    .imm    (i_imm),
    .data   (i_data),
    .result (result_d),
    .flag   (flag_d)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
      o_flag   <= 4'b0000;
    end else begin
      o_result <= result_d;
      o_flag   <= flag_d;
    end
  end

endmodule

// File: tb/tb_sck_alu.sv
// Scoreboard bench for sck_alu: stimulus pushes model predictions into a queue,
// a monitor pops and compares one registered result per clock.
module tb_sck_alu;

  typedef struct packed {
    logic [5:0] result;
    logic [3:0] flag;
  } exp_t;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_arg0;
  logic [5:0] i_arg1;
  logic [1:0] i_oper;
  logic       i_imm;
  logic [5:0] i_data;
  logic [5:0] o_result;
  logic [3:0] o_flag;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  sck_alu dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_arg0   (i_arg0),
    .i_arg1   (i_arg1),
    .i_oper   (i_oper),
    .i_imm    (i_imm),
    .i_data   (i_data),
    .o_result (o_result),
    .o_flag   (o_flag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int sval(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  // Reference model works on integers: wrap modulo 64, range-check for V.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] a,
                                 input logic [5:0] b);
    exp_t e;
    int   s;
    int   r;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = sval(a) + sval(b);
        c = (int'(a) + int'(b)) > 63;
        v = (s > 31) || (s < -32);
      end
      2'd1: begin
        s = sval(a) - sval(b);
        c = int'(a) < int'(b);
        v = (s > 31) || (s < -32);
      end
      2'd2: s = int'(a & b);
      default: s = int'(a | b);
    endcase
    r = ((s % 64) + 64) % 64;
    e.result = r[5:0];
    e.flag   = {v, c, (r >= 32), (r == 0)};
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got result=%0d flag=%b, expected result=%0d flag=%b",
               name, sval(act.result), act.flag, sval(req.result), req.flag);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] op, input logic [5:0] a,
                       input logic [5:0] b, input logic imm, input logic [5:0] d);
    exp_t e;
    @(negedge i_clk);
    i_rst  = rst;
    i_oper = op;
    i_arg0 = a;
    i_arg1 = b;
    i_imm  = imm;
    i_data = d;
    if (rst) e = '0;
    else     e = model(op, a, imm ? d : b);
    exp_q.push_back(e);
  endtask

  // Monitor: each edge after stimulus starts produces exactly one output.
  always @(posedge i_clk) begin
    exp_t act;
    exp_t req;
    #1;
    if (exp_q.size() != 0) begin
      req = exp_q.pop_front();
      act.result = o_result;
      act.flag   = o_flag;
      check("alu_out", act, req);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst  = 1'b1;
    i_oper = 2'd0;
    i_arg0 = '0;
    i_arg1 = '0;
    i_imm  = 1'b0;
    i_data = '0;

    // Reset held two edges with arbitrary operands.
    drive(1'b1, 2'd0, 6'd9, 6'd20, 1'b0, 6'd3);
    drive(1'b1, 2'd3, 6'd63, 6'd1, 1'b1, 6'd7);
    drive(1'b0, 2'd0, 6'd2, 6'd13, 1'b0, 6'd0);

    // Directed operations and boundary cases.
    drive(1'b0, 2'd2, 6'd3, 6'd1, 1'b0, 6'd0);
    drive(1'b0, 2'd3, 6'd5, 6'd2, 1'b0, 6'd0);
    drive(1'b0, 2'd1, 6'd1, 6'd1, 1'b0, 6'd0);
    drive(1'b0, 2'd0, 6'd17, 6'd18, 1'b0, 6'd0);
    drive(1'b0, 2'd1, 6'b100000, 6'd1, 1'b0, 6'd0);
    drive(1'b0, 2'd0, 6'd31, 6'd1, 1'b0, 6'd0);
    drive(1'b0, 2'd1, 6'd2, 6'd5, 1'b0, 6'd0);
    drive(1'b0, 2'd0, 6'b111111, 6'd1, 1'b0, 6'd0);
    drive(1'b0, 2'd1, 6'd22, 6'd22, 1'b0, 6'd0);
    drive(1'b0, 2'd0, 6'd4, 6'd25, 1'b1, 6'd10);
    drive(1'b0, 2'd0, 6'd4, 6'd25, 1'b0, 6'd10);

    // Reset on the same edge as an overflowing add, then resume.
    drive(1'b1, 2'd0, 6'd17, 6'd18, 1'b0, 6'd0);
    drive(1'b0, 2'd0, 6'd2, 6'd13, 1'b0, 6'd0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
            6'($urandom), 6'($urandom), 1'($urandom), 6'($urandom));
    end

    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
